// File: rtl/gpio.sv
// gpio: 32-bit memory-mapped GPIO with DATA_OUT/DIR/DATA_IN registers and a 2-flop input synchroniser.
// Optional rising-edge interrupt on input pins is enabled by defining GPIO_IRQ_EN.
`default_nettype none

module gpio #(
  parameter int unsigned WIDTH   = 32,
  parameter logic [31:0] RST_OUT = 32'h0000_0000,
  parameter logic [31:0] RST_DIR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        re,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out,
  output logic [31:0] gpio_dir,
  output logic        irq
);

  localparam logic [3:0] ADDR_OUT = 4'h0;
  localparam logic [3:0] ADDR_DIR = 4'h4;
  localparam logic [3:0] ADDR_IN  = 4'h8;
  localparam logic [3:0] ADDR_IRQ = 4'hC;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      rd_val;

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] sync3_q;
  logic [WIDTH-1:0] stat_q, stat_d;
  logic [WIDTH-1:0] rise;
  logic             irq_q;
`endif

  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    if (we) begin
      case (addr)
        ADDR_OUT: out_d = wdata[WIDTH-1:0];
        ADDR_DIR: dir_d = wdata[WIDTH-1:0];
        default:  ;
      endcase
    end
  end

  // Read mux sees the pre-write register values, so a same-edge write/read returns the old value.
  always_comb begin
    rd_val = '0;
    case (addr)
      ADDR_OUT: rd_val[WIDTH-1:0] = out_q;
      ADDR_DIR: rd_val[WIDTH-1:0] = dir_q;
      ADDR_IN:  rd_val[WIDTH-1:0] = sync2_q;
`ifdef GPIO_IRQ_EN
      ADDR_IRQ: rd_val[WIDTH-1:0] = stat_q;
`endif
      default:  rd_val = '0;
    endcase
  end

  assign rdata_d = re ? rd_val : rdata_q;

  always_comb begin
    gpio_dir = '0;
    gpio_out = '0;
    gpio_dir[WIDTH-1:0] = dir_q;
    gpio_out[WIDTH-1:0] = out_q & dir_q;
  end

  assign rdata = rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q   <= RST_OUT[WIDTH-1:0];
      dir_q   <= RST_DIR[WIDTH-1:0];
      sync1_q <= '0;
      sync2_q <= '0;
      rdata_q <= '0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      sync1_q <= gpio_in[WIDTH-1:0];
      sync2_q <= sync1_q;
      rdata_q <= rdata_d;
    end
  end

`ifdef GPIO_IRQ_EN
  // Edges are only recorded on pins currently configured as inputs; a new edge beats a same-cycle W1C.
  assign rise = sync2_q & ~sync3_q & ~dir_q;

  always_comb begin
    stat_d = stat_q;
    if (we && (addr == ADDR_IRQ)) begin
      stat_d = stat_d & ~wdata[WIDTH-1:0];
    end
    stat_d = stat_d | rise;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync3_q <= '0;
      stat_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      sync3_q <= sync2_q;
      stat_q  <= stat_d;
      irq_q   <= |stat_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gpio.sv
// tb_gpio: randomized scoreboard bench for gpio against a register-level reference model.
`default_nettype none

module tb_gpio;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [31:0] gpio_in = 32'h0;
  logic [31:0] gpio_out;
  logic [31:0] gpio_dir;
  logic        irq;

  gpio dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .re       (re),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_dir (gpio_dir),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  a;
    logic [31:0] v;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  // Reference model state: register contents and the settled pad value.
  logic [31:0] m_out = 32'h0;
  logic [31:0] m_dir = 32'h0;
  logic [31:0] m_pad = 32'h0;
  logic [31:0] m_stat = 32'h0;
  bit          irq_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [3:0] a);
    case (a)
      4'h0:    return m_out;
      4'h4:    return m_dir;
      4'h8:    return m_pad;
      4'hC:    return irq_en ? m_stat : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_wr(input logic [3:0] a, input logic [31:0] d);
    case (a)
      4'h0:    m_out = d;
      4'h4:    m_dir = d;
      4'hC:    if (irq_en) m_stat = m_stat & ~d;
      default: ;
    endcase
  endtask

  task automatic bus(input bit w, input bit r, input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    we = w; re = r; addr = a; wdata = d;
    if (r) exp_q.push_back('{a, model_rd(a)});
    if (w) model_wr(a, d);
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0;
  endtask

  task automatic rd_exp(input logic [3:0] a, input logic [31:0] v);
    @(negedge clk);
    re = 1'b1; addr = a;
    exp_q.push_back('{a, v});
    @(posedge clk);
    #1;
    re = 1'b0;
  endtask

  // Changes the pads and lets them settle through synchroniser and edge detector.
  task automatic pad(input logic [31:0] v);
    @(negedge clk);
    if (irq_en) m_stat = m_stat | (v & ~gpio_in & ~m_dir);
    gpio_in = v;
    repeat (3) @(posedge clk);
    #1;
    m_pad = v;
  endtask

  task automatic chk_pins();
    chk("gpio_dir", gpio_dir, m_dir);
    chk("gpio_out", gpio_out, m_out & m_dir);
    chk("irq", {31'h0, irq}, {31'h0, irq_en && (m_stat != 0)});
  endtask

  // Monitor: every read edge produces new rdata; pop the matching expectation.
  initial begin
    forever begin
      logic sampled;
      exp_t e;
      @(posedge clk);
      sampled = re;
      #2;
      if (sampled) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rdata_unexpected: got %08h expected no read", rdata);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("rdata@%1h", e.a), rdata, e.v);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef GPIO_IRQ_EN
    irq_en = 1'b1;
`else
    irq_en = 1'b0;
`endif
    // Reset held, then released with no access.
    repeat (3) @(negedge clk);
    chk("rst_gpio_out", gpio_out, 32'h0);
    chk("rst_gpio_dir", gpio_dir, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rel_rdata", rdata, 32'h0);
    chk_pins();

    bus(1, 0, 4'h4, 32'h0000_000F);
    bus(1, 0, 4'h0, 32'h0000_0005);
    chk("dir_f", gpio_dir, 32'h0000_000F);
    chk("out_5", gpio_out, 32'h0000_0005);
    bus(0, 1, 4'h0, 0);
    bus(0, 1, 4'h4, 0);

    bus(1, 0, 4'h0, 32'hDEAD_BEEF);
    bus(1, 0, 4'h4, 32'h0000_FFFF);
    chk("out_beef", gpio_out, 32'h0000_BEEF);
    bus(1, 0, 4'h4, 32'hFFFF_FFFF);
    chk("out_deadbeef", gpio_out, 32'hDEAD_BEEF);

    // Pad change: reads on the change edge and the next return the old value.
    @(negedge clk);
    gpio_in = 32'h0000_00A0;
    re = 1'b1; addr = 4'h8;
    exp_q.push_back('{4'h8, 32'h0});
    @(posedge clk);
    #1;
    re = 1'b0;
    rd_exp(4'h8, 32'h0);
    rd_exp(4'h8, 32'h0000_00A0);
    m_pad = 32'h0000_00A0;

    bus(0, 1, 4'h2, 0);
    bus(0, 1, 4'hC, 0);
    bus(1, 0, 4'h8, 32'h1234_5678);
    bus(0, 1, 4'h8, 0);
    bus(1, 1, 4'h0, 32'h0BAD_F00D);
    bus(0, 1, 4'h0, 0);
    chk_pins();

    // Edge interrupt on bit 4 with all pins inputs.
    bus(1, 0, 4'h4, 32'h0);
    pad(m_pad & ~32'h10);
    pad(m_pad | 32'h10);
    chk_pins();
    bus(0, 1, 4'hC, 0);
    bus(1, 0, 4'hC, 32'h10);
    chk_pins();
    bus(0, 1, 4'hC, 0);

    for (int i = 0; i < 120; i++) begin
      logic [3:0]  a;
      logic [31:0] d;
      int          op;
      op = $urandom_range(0, 3);
      case ($urandom_range(0, 4))
        0: a = 4'h0;
        1: a = 4'h4;
        2: a = 4'h8;
        3: a = 4'hC;
        default: a = 4'($urandom_range(0, 15));
      endcase
      d = $urandom;
      case (op)
        0: begin bus(1, 0, a, d); chk_pins(); end
        1: bus(0, 1, a, 0);
        2: begin bus(1, 1, a, d); chk_pins(); end
        default: begin pad($urandom); chk_pins(); end
      endcase
    end

    // Asynchronous reset mid-sequence.
    bus(1, 0, 4'h0, 32'hFFFF_FFFF);
    bus(1, 0, 4'h4, 32'h00FF_00FF);
    bus(0, 1, 4'h0, 0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    m_out = 32'h0; m_dir = 32'h0; m_stat = 32'h0;
    chk("arst_gpio_out", gpio_out, 32'h0);
    chk("arst_gpio_dir", gpio_dir, 32'h0);
    chk("arst_rdata", rdata, 32'h0);
    chk("arst_irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    if (irq_en) m_stat = m_pad & ~m_dir;
    repeat (3) @(posedge clk);
    #1;
    chk_pins();
    bus(0, 1, 4'h0, 0);
    bus(0, 1, 4'h8, 0);
    bus(0, 1, 4'hC, 0);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
